reg_dump_uart: RTL

Debug dump engine downstream of the processor top level. On a start pulse, steps the processor's 4-bit debug register index through R0..R15 and reads the selected 32-bit value from the debug output. Then captures the PC. Each of the 17 words is sent as ASCII hex over an 8N1 UART transmit line, giving a board-level register/PC dump without a logic analyser.

---
 rtl/reg_dump_uart.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reg_dump_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : reg_dump_uart
//  Description : Walks the processor debug port through R0..R15, then the PC,
//                and streams each word as 8 hex ASCII chars plus LF on 8N1 UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  debug_inp,
    input  logic [31:0] debug_outp,
    input  logic [31:0] PC,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int              TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      PC_IDX     = 5'd16;
    localparam logic [3:0]      LAST_CHAR  = 4'd8;
    localparam logic [3:0]      STOP_BIT   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [3:0]     debug_inp_q, debug_inp_d;
    logic [31:0]    word_q, word_d;
    logic [3:0]     char_q, char_d;
    logic [3:0]     bit_q, bit_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [7:0]     w_cur_byte;
    logic [2:0]     w_bit_sel;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return {4'h0, n} + ((n < 4'd10) ? 8'h30 : 8'h37);
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        debug_inp_d = debug_inp_q;
        word_d      = word_q;
        char_d      = char_q;
        bit_d       = bit_q;
        timer_d     = timer_q;
        tx          = 1'b1;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);

        w_cur_byte  = (char_q == LAST_CHAR) ? 8'h0A : hex_ascii(word_q[31:28]);
        // bit_q 1..8 carry data bits 0..7, LSB first
        w_bit_sel   = 3'(bit_q - 4'd1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d       = 5'd0;
                    debug_inp_d = 4'd0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                word_d  = (idx_q == PC_IDX) ? PC : debug_outp;
                char_d  = 4'd0;
                bit_d   = 4'd0;
                timer_d = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bit_q == 4'd0) begin
                    tx = 1'b0;
                end else if (bit_q == STOP_BIT) begin
                    tx = 1'b1;
                end else begin
                    tx = w_cur_byte[w_bit_sel];
                end

                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (bit_q == STOP_BIT) begin
                        bit_d = 4'd0;
                        if (char_q < LAST_CHAR) begin
                            char_d = char_q + 4'd1;
                            word_d = {word_q[27:0], 4'h0};
                        end else if (idx_q < PC_IDX) begin
                            idx_d       = idx_q + 5'd1;
                            // the PC record parks the debug index at 0
                            debug_inp_d = (idx_q < 5'd15) ? (idx_q[3:0] + 4'd1) : 4'd0;
                            state_d     = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            debug_inp_q <= 4'd0;
            word_q      <= 32'd0;
            char_q      <= 4'd0;
            bit_q       <= 4'd0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            debug_inp_q <= debug_inp_d;
            word_q      <= word_d;
            char_q      <= char_d;
            bit_q       <= bit_d;
            timer_q     <= timer_d;
        end
    end

    assign debug_inp = debug_inp_q;

endmodule
`default_nettype wire
